// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: queued words are sent LSB-first with optional parity and 1-2 stop bits.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise a single holding register is used.
module uart_tx_buffered #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200,
  parameter int DATA_BITS     = 8,
  parameter int PARITY_MODE   = 1,
  parameter int STOP_BITS     = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] din,
  output logic                 full,
  output logic                 empty,
  output logic                 busy,
  output logic                 overflow,
  output logic                 tx_out
);

  localparam int BIT_CLOCKS = CLK_FREQUENCY / BAUD_RATE;
  localparam int CNT_W      = (BIT_CLOCKS > 1) ? $clog2(BIT_CLOCKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CLOCKS - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic             PAR_INV   = (PARITY_MODE == 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_MODE < 0 || PARITY_MODE > 2 || BIT_CLOCKS < 1 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_tx_buffered: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     bit_cnt;
  logic [3:0]           bit_idx;
  logic                 tick;
  logic                 pop;
  logic                 push;
  logic [DATA_BITS-1:0] head;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] word);
    return (^word) ^ PAR_INV;
  endfunction

  // Queue: full is sampled before any same-edge pop, so a write to a full queue is always dropped.
  assign push = wr_en & ~full;

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count, count_nxt;

  always_comb count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == (AW + 1)'(FIFO_DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];
`else
  logic [DATA_BITS-1:0] hold;

  always_ff @(posedge clk) begin
    if (rst)       full <= 1'b0;
    else if (push) full <= 1'b1;
    else if (pop)  full <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) hold <= din;
  end

  assign empty = ~full;
  assign head  = hold;
`endif

  always_ff @(posedge clk) begin
    if (rst)                overflow <= 1'b0;
    else if (wr_en && full) overflow <= 1'b1;
  end

  assign busy = (state != IDLE) | ~empty;
  assign tick = (state != IDLE) && (bit_cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      end
      START:  if (tick) state_nxt = DATA;
      DATA: begin
        if (tick && bit_idx == DATA_LAST)
          state_nxt = (PARITY_MODE != 0) ? PARITY : STOP;
      end
      PARITY: if (tick) state_nxt = STOP;
      STOP: begin
        // Chain straight into the next start bit so queued frames leave no idle gap.
        if (tick && bit_idx == STOP_LAST) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Line is registered from the current state, so it trails the FSM by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      tx_out  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == IDLE || tick) bit_cnt <= '0;
      else                       bit_cnt <= bit_cnt + CNT_W'(1);
      if (state_nxt != state) bit_idx <= '0;
      else if (tick)          bit_idx <= bit_idx + 4'd1;
      case (state)
        START:   tx_out <= 1'b0;
        DATA:    tx_out <= shreg[0];
        PARITY:  tx_out <= par_bit;
        default: tx_out <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      shreg   <= head;
      par_bit <= parity_of(head);
    end else if (state == DATA && tick) begin
      shreg <= shreg >> 1;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: an 8O1 instance and a 7N2 instance, both at 11 clocks per bit.
`timescale 1ns/1ps
module tb_uart_tx_buffered;

  localparam int CLK_F = 100;
  localparam int BAUD  = 9;
  localparam int BC    = 11;   // 100 / 9 truncated

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       wr_a, full_a, empty_a, busy_a, ovf_a, tx_a;
  logic [7:0] din_a;
  logic       wr_b, full_b, empty_b, busy_b, ovf_b, tx_b;
  logic [6:0] din_b;

  uart_tx_buffered #(.CLK_FREQUENCY(CLK_F), .BAUD_RATE(BAUD), .DATA_BITS(8),
                     .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_a), .din(din_a), .full(full_a), .empty(empty_a),
    .busy(busy_a), .overflow(ovf_a), .tx_out(tx_a));

  uart_tx_buffered #(.CLK_FREQUENCY(CLK_F), .BAUD_RATE(BAUD), .DATA_BITS(7),
                     .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_b), .din(din_b), .full(full_b), .empty(empty_b),
    .busy(busy_b), .overflow(ovf_b), .tx_out(tx_b));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    logic [7:0] din;
    logic       exp_par;
  } vec_t;

  vec_t       vecs [5];
  logic [7:0] bw [6];
  int         nbw;
  logic [7:0] exp_q [$];
  logic       exp_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic line(input int sel);
    return (sel != 0) ? tx_b : tx_a;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel != 0) ? busy_b : busy_a;
  endfunction

  // Waits for a start bit, then samples every bit at its centre.
  task automatic rx_frame(input int sel, input int nbits, input bit has_par, input int nstop,
                          input int limit, output logic [8:0] data, output logic par,
                          output bit framing, output int scyc, output bit got);
    got = 0; data = '0; par = 1'b0; framing = 0; scyc = 0;
    for (int i = 0; i < limit; i++) begin
      if (line(sel) === 1'b0) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    if (!got) return;
    scyc = cyc;
    repeat (BC / 2) @(negedge clk);
    framing = (line(sel) === 1'b0);
    for (int b = 0; b < nbits; b++) begin
      repeat (BC) @(negedge clk);
      data[b] = line(sel);
    end
    if (has_par) begin
      repeat (BC) @(negedge clk);
      par = line(sel);
    end
    for (int s = 0; s < nstop; s++) begin
      repeat (BC) @(negedge clk);
      if (line(sel) !== 1'b1) framing = 0;
    end
  endtask

  task automatic wait_idle(input int sel, input int limit, output int fcyc, output bit got);
    got = 0; fcyc = 0;
    for (int i = 0; i < limit; i++) begin
      if (busy_of(sel) === 1'b0) begin
        got = 1;
        fcyc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_burst(input string tag);
    int prev;
    prev = 0;
    fork
      begin
        for (int i = 0; i < nbw; i++) begin
          wr_a = 1'b1; din_a = bw[i];
          @(negedge clk);
        end
        wr_a = 1'b0;
      end
      begin
        for (int f = 0; f < exp_q.size(); f++) begin
          logic [8:0] d; logic p; bit fr; int s; bit g;
          rx_frame(0, 8, 1, 1, 400, d, p, fr, s, g);
          check({tag, "_seen"}, 32'(g), 32'd1);
          check({tag, "_data"}, 32'(d), 32'(exp_q[f]));
          check({tag, "_framing"}, 32'(fr), 32'd1);
          if (f > 0) check({tag, "_gap"}, 32'(s - prev), 32'(11 * BC));
          prev = s;
        end
      end
    join
    begin
      logic [8:0] d; logic p; bit fr; int s; bit g;
      rx_frame(0, 8, 1, 1, 300, d, p, fr, s, g);
      check({tag, "_no_extra"}, 32'(g), 32'd0);
    end
    check({tag, "_overflow"}, 32'(ovf_a), 32'(exp_ovf));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] d; logic p; bit fr; int s; bit g; int wcyc; int fcyc; bit ok;

    vecs[0] = '{din: 8'hA5, exp_par: 1'b1};
    vecs[1] = '{din: 8'h34, exp_par: 1'b0};
    vecs[2] = '{din: 8'h07, exp_par: 1'b0};
    vecs[3] = '{din: 8'hFF, exp_par: 1'b1};
    vecs[4] = '{din: 8'h00, exp_par: 1'b1};

    rst = 1'b1; wr_a = 1'b0; din_a = '0; wr_b = 1'b0; din_b = '0;
    repeat (5) @(negedge clk);
    rst = 1'b0;

    // Reset state and a long quiet idle.
    check("rst_tx", 32'(tx_a), 32'd1);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_empty", 32'(empty_a), 32'd1);
    check("rst_full", 32'(full_a), 32'd0);
    check("rst_overflow", 32'(ovf_a), 32'd0);
    check("rst_tx_b", 32'(tx_b), 32'd1);
    ok = 1;
    repeat (1000) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || empty_a !== 1'b1) ok = 0;
    end
    check("idle_hold", 32'(ok), 32'd1);

    // Single frames, 8O1.
    for (int v = 0; v < 5; v++) begin
      wr_a = 1'b1; din_a = vecs[v].din;
      @(negedge clk);
      wcyc = cyc; wr_a = 1'b0;
      check("vec_busy_rise", 32'(busy_a), 32'd1);
      check("vec_empty_after_wr", 32'(empty_a), 32'd0);
      rx_frame(0, 8, 1, 1, 50, d, p, fr, s, g);
      check("vec_seen", 32'(g), 32'd1);
      check("vec_latency", 32'(s - wcyc), 32'd2);
      check("vec_data", 32'(d), 32'(vecs[v].din));
      check("vec_parity", 32'(p), 32'(vecs[v].exp_par));
      check("vec_framing", 32'(fr), 32'd1);
      wait_idle(0, 50, fcyc, g);
      check("vec_idle_seen", 32'(g), 32'd1);
      check("vec_busy_fall", 32'(fcyc - wcyc), 32'(1 + 11 * BC));
    end

    // Four-word burst.
    do_reset();
    bw[0] = 8'h00; bw[1] = 8'hFF; bw[2] = 8'h3C; bw[3] = 8'h81; nbw = 4;
`ifdef UART_TX_FIFO_EN
    exp_q = '{8'h00, 8'hFF, 8'h3C, 8'h81}; exp_ovf = 1'b0;
`else
    exp_q = '{8'h00, 8'h3C}; exp_ovf = 1'b1;
`endif
    run_burst("burst4");

    // Six-word burst overruns the queue.
    do_reset();
    bw[0] = 8'h11; bw[1] = 8'h22; bw[2] = 8'h33; bw[3] = 8'h44; bw[4] = 8'h55; bw[5] = 8'h66;
    nbw = 6;
`ifdef UART_TX_FIFO_EN
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
`else
    exp_q = '{8'h11, 8'h33};
`endif
    exp_ovf = 1'b1;
    run_burst("burst6");

    // 7N2 frame: ten bit times, no parity.
    do_reset();
    wr_b = 1'b1; din_b = 7'h55;
    @(negedge clk);
    wcyc = cyc; wr_b = 1'b0;
    rx_frame(1, 7, 0, 2, 50, d, p, fr, s, g);
    check("n2_seen", 32'(g), 32'd1);
    check("n2_latency", 32'(s - wcyc), 32'd2);
    check("n2_data", 32'(d), 32'h55);
    check("n2_framing", 32'(fr), 32'd1);
    wait_idle(1, 50, fcyc, g);
    check("n2_idle_seen", 32'(g), 32'd1);
    check("n2_busy_fall", 32'(fcyc - wcyc), 32'(1 + 10 * BC));

    // Reset in the middle of a data bit with words still queued.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wr_a = 1'b1;
      din_a = (i == 0) ? 8'h12 : ((i == 1) ? 8'h56 : 8'h78);
      @(negedge clk);
    end
    wr_a = 1'b0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (tx_a === 1'b0) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check("mid_start_seen", 32'(ok), 32'd1);
    repeat (BC / 2 + 4 * BC) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", 32'(tx_a), 32'd1);
    check("mid_rst_empty", 32'(empty_a), 32'd1);
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    check("mid_rst_overflow", 32'(ovf_a), 32'd0);
    rst = 1'b0;
    rx_frame(0, 8, 1, 1, 300, d, p, fr, s, g);
    check("mid_no_frame", 32'(g), 32'd0);
    wr_a = 1'b1; din_a = 8'h34;
    @(negedge clk);
    wcyc = cyc; wr_a = 1'b0;
    rx_frame(0, 8, 1, 1, 50, d, p, fr, s, g);
    check("post_rst_seen", 32'(g), 32'd1);
    check("post_rst_latency", 32'(s - wcyc), 32'd2);
    check("post_rst_data", 32'(d), 32'h34);
    check("post_rst_parity", 32'(p), 32'd0);
    check("post_rst_framing", 32'(fr), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
